ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter. It is the opposite direction to the existing PS/2 keyboard receiver. It accepts a byte over a valid/ready handshake and runs the host request-to-send sequence: inhibit clock, start bit, 8 data bits LSB first, odd parity, stop, then device ACK. Used to send keyboard commands, e.g. 0xED plus LED byte driven from the caps-lock/shift-lock latch bits. It shares PS2_CLK/PS2_DATA through open-drain pads in TOP.

Parameters:
INHIBIT_TICKS, 200, clk_en ticks clock is held low before the start bit (≥100 µs).
TIMEOUT_TICKS, 4000, clk_en ticks allowed between device clock falling edges (and for ACK) before abort.

Ports:
clk  in  1  system clock (PIXELCLK)
RESET  in  1  asynchronous, active-high reset
clk_en  in  1  timebase tick for inhibit/timeout counters
tx_data  in  8  byte to send
tx_valid  in  1  request; byte accepted when tx_valid & tx_ready
tx_ready  out  1  idle, can accept a byte
PS2_CLK  in  1  pad clock level (asynchronous)
PS2_DATA  in  1  pad data level (asynchronous)
ps2_clk_oe  out  1  1 = pull clock line low
ps2_data_oe  out  1  1 = pull data line low
busy  out  1  transfer in progress; receiver must ignore line activity
done  out  1  one-clk pulse: ACK received
error  out  1  one-clk pulse: no ACK or timeout

Behaviour:
- Reset (async, takes effect immediately): state IDLE; tx_ready=1; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, error=0; counters and shift register cleared.
- PS2_CLK/PS2_DATA pass through 2-FF synchronisers, then a third stage. Falling edge fe = prev & ~cur on the synchronised clock.
- Handshake: on tx_valid & tx_ready, latch tx_data. Compute parity = ~^tx_data (odd). Next cycle: tx_ready=0, busy=1, state INHIBIT. tx_valid while busy is ignored; no queueing.
- INHIBIT: ps2_clk_oe=1. Count clk_en ticks. When the count reaches INHIBIT_TICKS, set ps2_data_oe=1 (start bit 0) in the same cycle and go to RELEASE.
- RELEASE: ps2_clk_oe=0 on the following cycle. ps2_data_oe stays 1. Clear timeout counter. Go to DATA with bit index 0.
- DATA: on each fe, ps2_data_oe = ~shift[0], shift right, index+1. The first fe presents D0. After the fe that presents D7 (index reaches 8), go to PARITY.
- PARITY: on fe, ps2_data_oe = ~parity. Go to STOP.
- STOP: on fe, ps2_data_oe=0 (release, line reads 1). Go to ACK.
- ACK: on fe, sample synchronised data. If 0, go to WAIT_IDLE. If 1, pulse error and go to ABORT.
- WAIT_IDLE: wait for synchronised clock=1 and data=1. Then pulse done, go to IDLE, tx_ready=1, busy=0.
- Timeout: in RELEASE, DATA, PARITY, STOP, ACK and WAIT_IDLE, a counter increments per clk_en and clears on every fe. When it reaches TIMEOUT_TICKS, pulse error and go to ABORT.
- ABORT: both oe=0 for one cycle, then IDLE.
- Edge cases:
  - fe during INHIBIT is ignored; the host owns the clock then.
  - fe and timeout in the same cycle: fe wins.
  - clk_en=0 freezes the counters only; edge detection still runs every clk.
- done and error are mutually exclusive; each is exactly one clk wide.
- Latency: byte accept to start bit = 1 + INHIBIT_TICKS clk_en ticks. Device-clock-paced thereafter: 11 falling edges to ACK.

Test Plan:
- Reset mid-DATA (after 4 fe): assert RESET → oe outputs 0 same cycle, tx_ready=1, busy=0, no done/error.
- Send 0xED with a device model clocking at ~12 kHz → clk held low ≥INHIBIT_TICKS ticks. Model samples on rising edges: start 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Model ACKs → one done pulse, tx_ready back to 1.
- Send 0x00 → parity bit 1. Send 0x07 → parity bit 0. Both complete with done.
- Device gives no ACK (data stays 1 at 11th fe) → error pulse, no done, both lines released.
- Device stops clocking after the 3rd fe → error exactly TIMEOUT_TICKS clk_en ticks after the last fe; lines released, IDLE.
- tx_valid held high with 0x55 then 0xAA queued behind it → only 0x55 transmitted until tx_ready returns. 0xAA is accepted on the first ready cycle afterwards; both frames are correct on the wire.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter.
// Takes one byte over a valid/ready handshake and runs the host request-to-send
// sequence on the shared open-drain PS/2 lines. The clock is inhibited first,
// then the start bit goes out, then 8 data bits LSB first, odd parity and stop.
// Finally the device ACK is checked. Used for keyboard commands such as 0xED
// followed by the LED byte.
//
// Ports:
//   clk          system clock (PIXELCLK domain)
//   RESET        asynchronous, active-high reset
//   clk_en       timebase tick; advances the inhibit/timeout counter only
//   tx_data      byte to send, latched when tx_valid & tx_ready
//   tx_valid     send request
//   tx_ready     idle, a byte can be accepted
//   PS2_CLK      pad clock level (asynchronous to clk)
//   PS2_DATA     pad data level (asynchronous to clk)
//   ps2_clk_oe   1 = pull the clock line low
//   ps2_data_oe  1 = pull the data line low
//   busy         transfer in progress; the receiver ignores line activity
//   done         one-clk pulse: device ACK received and lines idle
//   error        one-clk pulse: missing ACK or device clock timeout
module ps2_host_tx #(
  parameter int INHIBIT_TICKS = 200,
  parameter int TIMEOUT_TICKS = 4000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       clk_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  // One counter serves both the inhibit phase and the device-clock timeout.
  localparam int CNT_MAX = (INHIBIT_TICKS > TIMEOUT_TICKS) ? INHIBIT_TICKS : TIMEOUT_TICKS;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE      = CW'(32'd1);
  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_TICKS - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_TICKS - 1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_INHIBIT   = 4'd1,
    ST_RELEASE   = 4'd2,
    ST_DATA      = 4'd3,
    ST_PARITY    = 4'd4,
    ST_STOP      = 4'd5,
    ST_ACK       = 4'd6,
    ST_WAIT_IDLE = 4'd7,
    ST_ABORT     = 4'd8
  } state_t;

  // Odd parity bit: makes the total count of ones in data+parity odd.
  function automatic logic odd_parity(input logic [7:0] d);
    odd_parity = ~(^d);
  endfunction

  state_t        state_r, state_n;
  logic [7:0]    shift_r, shift_n;
  logic          parity_r, parity_n;
  logic [3:0]    idx_r, idx_n;
  logic [CW-1:0] cnt_r, cnt_n;
  logic          tx_ready_r, tx_ready_n;
  logic          clk_oe_r, clk_oe_n;
  logic          data_oe_r, data_oe_n;
  logic          busy_r, busy_n;
  logic          done_r, done_n;
  logic          error_r, error_n;
  logic          clk_s1_r, clk_s2_r, clk_s3_r;
  logic          data_s1_r, data_s2_r;
  logic          fe_s;
  logic          watch_s;

  // Synchronisers reset to 1 (idle bus level) so reset never fakes an edge.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      clk_s1_r  <= 1'b1;
      clk_s2_r  <= 1'b1;
      clk_s3_r  <= 1'b1;
      data_s1_r <= 1'b1;
      data_s2_r <= 1'b1;
    end else begin
      clk_s1_r  <= PS2_CLK;
      clk_s2_r  <= clk_s1_r;
      clk_s3_r  <= clk_s2_r;
      data_s1_r <= PS2_DATA;
      data_s2_r <= data_s1_r;
    end
  end

  assign fe_s    = clk_s3_r & ~clk_s2_r;
  assign watch_s = (state_r == ST_DATA) || (state_r == ST_PARITY) || (state_r == ST_STOP) ||
                   (state_r == ST_ACK) || (state_r == ST_WAIT_IDLE);

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_r    <= ST_IDLE;
      shift_r    <= 8'h00;
      parity_r   <= 1'b0;
      idx_r      <= 4'd0;
      cnt_r      <= CNT_ZERO;
      tx_ready_r <= 1'b1;
      clk_oe_r   <= 1'b0;
      data_oe_r  <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      state_r    <= state_n;
      shift_r    <= shift_n;
      parity_r   <= parity_n;
      idx_r      <= idx_n;
      cnt_r      <= cnt_n;
      tx_ready_r <= tx_ready_n;
      clk_oe_r   <= clk_oe_n;
      data_oe_r  <= data_oe_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
      error_r    <= error_n;
    end
  end

  // Next-state and next-output logic for the request-to-send sequence.
  always_comb begin
    state_n    = state_r;
    shift_n    = shift_r;
    parity_n   = parity_r;
    idx_n      = idx_r;
    cnt_n      = cnt_r;
    tx_ready_n = tx_ready_r;
    clk_oe_n   = clk_oe_r;
    data_oe_n  = data_oe_r;
    busy_n     = busy_r;
    done_n     = 1'b0;
    error_n    = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (tx_valid && tx_ready_r) begin
          shift_n    = tx_data;
          parity_n   = odd_parity(tx_data);
          idx_n      = 4'd0;
          cnt_n      = CNT_ZERO;
          tx_ready_n = 1'b0;
          busy_n     = 1'b1;
          clk_oe_n   = 1'b1;
          data_oe_n  = 1'b0;
          state_n    = ST_INHIBIT;
        end else begin
          tx_ready_n = 1'b1;
        end
      end
      // Device clock edges are ignored here: the host is holding the clock.
      ST_INHIBIT: begin
        if (clk_en) begin
          if (cnt_r == INHIBIT_LAST) begin
            data_oe_n = 1'b1;
            cnt_n     = CNT_ZERO;
            state_n   = ST_RELEASE;
          end else begin
            cnt_n = cnt_r + CNT_ONE;
          end
        end else begin
          cnt_n = cnt_r;
        end
      end
      ST_RELEASE: begin
        clk_oe_n = 1'b0;
        cnt_n    = CNT_ZERO;
        idx_n    = 4'd0;
        state_n  = ST_DATA;
      end
      ST_DATA: begin
        if (fe_s) begin
          data_oe_n = ~shift_r[0];
          shift_n   = {1'b0, shift_r[7:1]};
          idx_n     = idx_r + 4'd1;
          if (idx_r == 4'd7) begin
            state_n = ST_PARITY;
          end else begin
            state_n = ST_DATA;
          end
        end else begin
          state_n = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (fe_s) begin
          data_oe_n = ~parity_r;
          state_n   = ST_STOP;
        end else begin
          state_n = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (fe_s) begin
          data_oe_n = 1'b0;
          state_n   = ST_ACK;
        end else begin
          state_n = ST_STOP;
        end
      end
      ST_ACK: begin
        if (fe_s) begin
          if (!data_s2_r) begin
            state_n = ST_WAIT_IDLE;
          end else begin
            error_n   = 1'b1;
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            state_n   = ST_ABORT;
          end
        end else begin
          state_n = ST_ACK;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s2_r && data_s2_r) begin
          done_n     = 1'b1;
          tx_ready_n = 1'b1;
          busy_n     = 1'b0;
          state_n    = ST_IDLE;
        end else begin
          state_n = ST_WAIT_IDLE;
        end
      end
      ST_ABORT: begin
        clk_oe_n   = 1'b0;
        data_oe_n  = 1'b0;
        tx_ready_n = 1'b1;
        busy_n     = 1'b0;
        state_n    = ST_IDLE;
      end
      default: begin
        clk_oe_n   = 1'b0;
        data_oe_n  = 1'b0;
        tx_ready_n = 1'b1;
        busy_n     = 1'b0;
        state_n    = ST_IDLE;
      end
    endcase

    // Device-paced phases: every falling edge restarts the timeout, and an edge
    // in the same cycle as the final tick wins. A completing WAIT_IDLE also wins.
    if (watch_s) begin
      if (fe_s) begin
        cnt_n = CNT_ZERO;
      end else if (clk_en && !done_n) begin
        if (cnt_r == TIMEOUT_LAST) begin
          error_n   = 1'b1;
          clk_oe_n  = 1'b0;
          data_oe_n = 1'b0;
          cnt_n     = CNT_ZERO;
          state_n   = ST_ABORT;
        end else begin
          cnt_n = cnt_r + CNT_ONE;
        end
      end else begin
        cnt_n = cnt_n;
      end
    end else begin
      cnt_n = cnt_n;
    end
  end

  assign tx_ready    = tx_ready_r;
  assign ps2_clk_oe  = clk_oe_r;
  assign ps2_data_oe = data_oe_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign error       = error_r;

endmodule
